// File: rtl/btn_conditioner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btn_conditioner_pkg
// Description : Shared constants, press-FSM state encoding and helper
//               functions for the push-button conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
package btn_conditioner_pkg;

    localparam int NUM_BTNS                = 4;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

    // Press FSM state encoding
    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_HELD    = 2'd1;
    localparam logic [1:0] c_ST_LOCKOUT = 2'd2;

    // Number of buttons currently high
    function automatic logic [2:0] f_popcount(input logic [NUM_BTNS-1:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < NUM_BTNS; i++) begin
            n = n + 3'(v[i]);
        end
        return n;
    endfunction

    // Index of the lowest high bit; only meaningful when exactly one bit is set
    function automatic logic [1:0] f_btn_index(input logic [NUM_BTNS-1:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NUM_BTNS - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage : btn_conditioner_pkg
`default_nettype wire

// File: rtl/btn_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : btn_conditioner_if
// Description : Raw button inputs and conditioned press outputs.
//               master = button/consumer side, slave = conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
interface btn_conditioner_if;
    import btn_conditioner_pkg::*;

    logic [NUM_BTNS-1:0] btns;
    logic [NUM_BTNS-1:0] btns_clean;
    logic                pressed;
    logic                press_pulse;
    logic [1:0]          press_num;
    logic                conflict;

    modport master (
        output btns,
        input  btns_clean,
        input  pressed,
        input  press_pulse,
        input  press_num,
        input  conflict
    );

    modport slave (
        input  btns,
        output btns_clean,
        output pressed,
        output press_pulse,
        output press_num,
        output conflict
    );

endinterface : btn_conditioner_if
`default_nettype wire

// File: rtl/btn_conditioner_debounce_bit.sv
`default_nettype none
// ============================================================================
// Module      : debounce_bit
// Description : Two-flop synchronizer followed by a stable-level counter for
//               one push-button. The clean level flips only after the
//               synchronized input has disagreed with it for DEBOUNCE_CYCLES
//               consecutive cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_btn,
    output logic      o_clean
);

    localparam int                 c_CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               r_meta;
    logic               r_sync;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_clean;

    // Bring the asynchronous button level into the clk domain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_btn;
            r_sync <= r_meta;
        end
    end

    // Count consecutive disagreeing cycles; flip the clean level at the limit
    // so the counter clears before it could ever wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_clean <= 1'b0;
        end else if (r_sync == r_clean) begin
            r_cnt   <= '0;
        end else if (r_cnt == c_CNT_MAX) begin
            r_cnt   <= '0;
            r_clean <= ~r_clean;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign o_clean = r_clean;

endmodule : debounce_bit
`default_nettype wire

// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : btn_conditioner
// Description : Debounces four push-buttons and accepts single-button presses.
//               A press of exactly one button yields a one-cycle strobe and
//               its index; any multi-button activity locks out new presses
//               until every button has been released.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_conditioner
    import btn_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  wire logic       clk,
    input  wire logic       reset,
    btn_conditioner_if.slave bus
);

    logic [NUM_BTNS-1:0] w_clean;
    logic [2:0]          w_pop;
    logic [NUM_BTNS-1:0] w_held_mask;

    logic [1:0]          r_state;
    logic                r_pressed;
    logic                r_pulse;
    logic [1:0]          r_num;

    generate
        for (genvar i = 0; i < NUM_BTNS; i++) begin : g_debounce
            debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce_bit (
                .clk     (clk),
                .rst     (reset),
                .i_btn   (bus.btns[i]),
                .o_clean (w_clean[i])
            );
        end
    endgenerate

    assign w_pop       = f_popcount(w_clean);
    assign w_held_mask = NUM_BTNS'(1) << r_num;

    // Press acceptance FSM; outputs are registered alongside the state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_pressed <= 1'b0;
            r_pulse   <= 1'b0;
            r_num     <= 2'd0;
        end else begin
            r_pulse <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_pop == 3'd1) begin
                        r_state   <= c_ST_HELD;
                        r_pulse   <= 1'b1;
                        r_pressed <= 1'b1;
                        r_num     <= f_btn_index(w_clean);
                    end else if (w_pop >= 3'd2) begin
                        r_state   <= c_ST_LOCKOUT;
                    end
                end
                c_ST_HELD: begin
                    // Anything other than the accepted button alone ends the
                    // press; a swap to another button also needs a full release
                    if (w_clean == '0) begin
                        r_state   <= c_ST_IDLE;
                        r_pressed <= 1'b0;
                    end else if (w_clean != w_held_mask) begin
                        r_state   <= c_ST_LOCKOUT;
                        r_pressed <= 1'b0;
                    end
                end
                c_ST_LOCKOUT: begin
                    if (w_clean == '0) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state   <= c_ST_IDLE;
                    r_pressed <= 1'b0;
                end
            endcase
        end
    end

    assign bus.btns_clean  = w_clean;
    assign bus.pressed     = r_pressed;
    assign bus.press_pulse = r_pulse;
    assign bus.press_num   = r_num;
    assign bus.conflict    = (w_pop >= 3'd2);

endmodule : btn_conditioner
`default_nettype wire

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, SHALL set the number of consecutive stable clk cycles a synchronized button must hold before its debounced level changes (10 ms at 100 MHz); legal range 2..2^24-1.
REQ-002 clk  input  1  system clock; single clock domain, every register clocked on rising edge.
REQ-003 reset  input  1  reset; synchronous, active-high.
REQ-004 btns  input  4  raw asynchronous push-button levels, 1 = pressed; bit i = button i.
REQ-005 btns_clean  output  4  debounced button levels, registered.
REQ-006 pressed  output  1  level, 1 while exactly the accepted button is held; feeds the existing button-to-number decode path.
REQ-007 press_pulse  output  1  one-cycle strobe marking acceptance of a new single-button press.
REQ-008 press_num  output  2  index of the accepted button; valid while pressed=1; holds its value otherwise.
REQ-009 conflict  output  1  level, 1 while more than one debounced button is high.

Function
REQ-010 Each btns bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-011 Per bit, a counter SHALL clear whenever the synchronized level equals btns_clean[i] and increment otherwise.
REQ-012 When the counter equals DEBOUNCE_CYCLES-1 and the levels still differ, btns_clean[i] SHALL toggle on the next edge and the counter SHALL clear.
REQ-013 A raw change held steady SHALL appear on btns_clean exactly DEBOUNCE_CYCLES+2 cycles after the first clk edge that samples it; any glitch shorter than DEBOUNCE_CYCLES cycles after synchronization SHALL have no effect.
REQ-014 Counter width SHALL be ceil(log2(DEBOUNCE_CYCLES)); the counter SHALL never wrap.
REQ-015 Press FSM states: IDLE, HELD, LOCKOUT.
REQ-016 IDLE -> HELD when btns_clean has exactly one bit high: press_pulse=1 for the next cycle, press_num=index of that bit, pressed=1.
REQ-017 IDLE -> LOCKOUT when btns_clean has two or more bits high in the same cycle; no press_pulse.
REQ-018 HELD -> IDLE when btns_clean becomes 0000; pressed SHALL drop on the following cycle.
REQ-019 HELD -> LOCKOUT when any second bit of btns_clean rises; pressed SHALL drop on the following cycle; press_num unchanged.
REQ-020 LOCKOUT -> IDLE only when btns_clean is 0000; a new press SHALL require a full release first.
REQ-021 press_pulse, pressed and press_num SHALL register one cycle after the btns_clean change that causes them.
REQ-022 conflict SHALL be combinational popcount(btns_clean) >= 2, independent of FSM state.
REQ-023 Button index encoding: bit0 -> 0, bit1 -> 1, bit2 -> 2, bit3 -> 3.

Reset
REQ-024 While reset=1 on a clk edge: synchronizers, counters and btns_clean SHALL clear to 0; FSM SHALL enter IDLE; pressed=0, press_pulse=0, press_num=00.
REQ-025 A button held through reset release SHALL be treated as a new press after the normal DEBOUNCE_CYCLES+2 latency.
REQ-026 Reset asserted mid-debounce or mid-press SHALL discard all progress and emit no pulse.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (IDLE=0, HELD=1, LOCKOUT=2), NUM_BTNS=4 and the default DEBOUNCE_CYCLES.
REQ-028 Per-bit synchronization and debouncing SHALL live in one sub-module, debounce_bit, instantiated four times; the press FSM SHALL stay in btn_conditioner.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 btns=0001 held 20 cycles from reset release -> btns_clean[0]=1 at cycle 6, press_pulse one cycle at cycle 7, press_num=0, pressed=1 until 7 cycles after release.
REQ-030 btns[2] toggled 1,0,1,0 each cycle for 8 cycles, then 0 -> btns_clean stays 0000, no press_pulse.
REQ-031 btns=0110 applied in one cycle -> conflict=1, FSM LOCKOUT, no press_pulse; then btns=0100 only -> still no pulse until 0000 is seen, then a new 0100 press gives press_num=2.
REQ-032 Hold 1000 (accepted, press_num=3), then add 0001 -> pressed drops, conflict=1, press_num stays 3, no second pulse.
REQ-033 reset asserted 3 cycles into a debounce of btns=0010 -> all outputs 0; after release, pulse arrives DEBOUNCE_CYCLES+3 cycles later with press_num=1.
